// File: rtl/c4_pkg.sv
// Shared definitions for the Connect Four draw sequencer.
//   - Colour codes for the cell drawer (background, red, yellow)
//   - Default board dimensions and pointer start column
//   - Coordinate widths and the sequencer state enum
package c4_pkg;

   localparam int unsigned COL_W = 3;
   localparam int unsigned ROW_W = 3;
   localparam int unsigned CLR_W = 3;

   localparam int unsigned DEF_COLS      = 7;
   localparam int unsigned DEF_ROWS      = 6;
   localparam int unsigned DEF_START_COL = 3;

   localparam logic [CLR_W-1:0] BG     = 3'b000;
   localparam logic [CLR_W-1:0] RED    = 3'b100;
   localparam logic [CLR_W-1:0] YELLOW = 3'b110;

   typedef enum logic [2:0] {
      StInitPtr,
      StIdle,
      StErasePtr,
      StDrawPiece,
      StDrawPtr
   } state_e;

   function automatic logic [CLR_W-1:0] player_colour(input logic p);
      return p ? YELLOW : RED;
   endfunction

endpackage

// File: rtl/c4_draw_req.sv
// Handshake holder for one cell-draw request.
// Ports:
//   clk, resetn              clock, async active-low reset
//   start                    capture col/row/colour; draw_go rises next cycle
//   col, row, colour         request fields to capture
//   draw_done                drawer completion (ignored while draw_go is low)
//   draw_go                  request valid, held until draw_done is seen
//   draw_col/row/colour      registered request fields, stable while draw_go
//   req_complete             combinational pulse: draw_done accepted this cycle
module c4_draw_req
   import c4_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row,
   input  logic [CLR_W-1:0] colour,
   input  logic             draw_done,
   output logic             draw_go,
   output logic [COL_W-1:0] draw_col,
   output logic [ROW_W-1:0] draw_row,
   output logic [CLR_W-1:0] draw_colour,
   output logic             req_complete
);

   logic             go_q;
   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic [CLR_W-1:0] colour_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         go_q     <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         colour_q <= '0;
      end else if (start) begin
         go_q     <= 1'b1;
         col_q    <= col;
         row_q    <= row;
         colour_q <= colour;
      end else if (go_q && draw_done) begin
         go_q <= 1'b0;
      end
   end

   assign req_complete = go_q & draw_done;
   assign draw_go      = go_q;
   assign draw_col     = col_q;
   assign draw_row     = row_q;
   assign draw_colour  = colour_q;

endmodule

// File: rtl/c4_draw_sequencer.sv
// Connect Four draw sequencer: turns move/drop commands into single-cell
// draw requests for the pixel drawer and tracks the game state.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   move_left/move_right/drop      one-cycle commands, sampled only in IDLE
//   cmd_ready                      high while idle
//   draw_go/col/row/colour         request to the cell drawer
//   draw_done                      drawer completion pulse
//   player                         0 = red, 1 = yellow
//   board_full                     piece_count has reached COLS*ROWS
//   illegal_move                   one-cycle pulse on a rejected drop
//   piece_count                    pieces placed so far
module c4_draw_sequencer
   import c4_pkg::*;
#(
   parameter int unsigned COLS      = DEF_COLS,
   parameter int unsigned ROWS      = DEF_ROWS,
   parameter int unsigned START_COL = DEF_START_COL
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             move_left,
   input  logic             move_right,
   input  logic             drop,
   output logic             cmd_ready,
   output logic             draw_go,
   output logic [COL_W-1:0] draw_col,
   output logic [ROW_W-1:0] draw_row,
   output logic [CLR_W-1:0] draw_colour,
   input  logic             draw_done,
   output logic             player,
   output logic             board_full,
   output logic             illegal_move,
   output logic [5:0]       piece_count
);

   localparam logic [5:0]       MAX_PIECES = 6'(COLS * ROWS);
   localparam logic [ROW_W-1:0] PTR_ROW    = ROW_W'(ROWS);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);

   state_e           state_q;
   logic             start_q;
   logic             cmd_ready_q;
   logic             illegal_q;
   logic             player_q;
   logic [5:0]       count_q;
   logic [COL_W-1:0] ptr_col_q;
   logic [COL_W-1:0] target_q;
   logic [ROW_W-1:0] height_q [COLS];

   logic             req_complete;
   logic [COL_W-1:0] req_col;
   logic [ROW_W-1:0] req_row;
   logic [CLR_W-1:0] req_colour;
   logic [ROW_W-1:0] cur_height;

   assign cur_height = height_q[ptr_col_q];
   assign board_full = (count_q == MAX_PIECES);

   // Fields for the request of the current draw state; captured by the
   // holder one cycle after state entry, so updates made on the previous
   // completion (pointer column, player) are already visible.
   always_comb begin
      req_col    = ptr_col_q;
      req_row    = PTR_ROW;
      req_colour = player_colour(player_q);
      case (state_q)
         StErasePtr:  req_colour = BG;
         StDrawPiece: req_row    = cur_height;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StInitPtr;
         start_q     <= 1'b1;  // first request after reset is the pointer
         cmd_ready_q <= 1'b0;
         illegal_q   <= 1'b0;
         player_q    <= 1'b0;
         count_q     <= '0;
         ptr_col_q   <= COL_W'(START_COL);
         target_q    <= COL_W'(START_COL);
         for (int i = 0; i < COLS; i++) height_q[i] <= '0;
      end else begin
         start_q   <= 1'b0;
         illegal_q <= 1'b0;
         unique case (state_q)
            StInitPtr: begin
               if (req_complete) begin
                  state_q     <= StIdle;
                  cmd_ready_q <= 1'b1;
               end
            end
            StIdle: begin
               // Priority drop > move_left > move_right; losers are dropped.
               if (drop) begin
                  if (board_full || (cur_height >= PTR_ROW)) begin
                     illegal_q <= 1'b1;
                  end else begin
                     state_q     <= StDrawPiece;
                     start_q     <= 1'b1;
                     cmd_ready_q <= 1'b0;
                  end
               end else if (move_left) begin
                  if (ptr_col_q != '0) begin
                     target_q    <= ptr_col_q - COL_W'(1);
                     state_q     <= StErasePtr;
                     start_q     <= 1'b1;
                     cmd_ready_q <= 1'b0;
                  end
               end else if (move_right) begin
                  if (ptr_col_q != LAST_COL) begin
                     target_q    <= ptr_col_q + COL_W'(1);
                     state_q     <= StErasePtr;
                     start_q     <= 1'b1;
                     cmd_ready_q <= 1'b0;
                  end
               end
            end
            StErasePtr: begin
               if (req_complete) begin
                  ptr_col_q <= target_q;
                  state_q   <= StDrawPtr;
                  start_q   <= 1'b1;
               end
            end
            StDrawPiece: begin
               if (req_complete) begin
                  if (cur_height < PTR_ROW) height_q[ptr_col_q] <= cur_height + ROW_W'(1);
                  if (count_q < MAX_PIECES) count_q <= count_q + 6'd1;
                  player_q <= ~player_q;
                  state_q  <= StDrawPtr;
                  start_q  <= 1'b1;
               end
            end
            StDrawPtr: begin
               if (req_complete) begin
                  state_q     <= StIdle;
                  cmd_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StInitPtr;
               start_q <= 1'b1;
            end
         endcase
      end
   end

   c4_draw_req u_draw_req (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start_q),
      .col          (req_col),
      .row          (req_row),
      .colour       (req_colour),
      .draw_done    (draw_done),
      .draw_go      (draw_go),
      .draw_col     (draw_col),
      .draw_row     (draw_row),
      .draw_colour  (draw_colour),
      .req_complete (req_complete)
   );

   assign cmd_ready    = cmd_ready_q;
   assign illegal_move = illegal_q;
   assign player       = player_q;
   assign piece_count  = count_q;

endmodule

// File: tb/tb_c4_draw_sequencer.sv
// Scoreboard bench: stimulus pushes expected draw requests, a monitor pops
// and compares them on every rising draw_go; a drawer model answers each
// request with draw_done three cycles after draw_go rises.
module tb_c4_draw_sequencer;

   localparam logic [2:0] C_BG = 3'b000;
   localparam logic [2:0] C_R  = 3'b100;
   localparam logic [2:0] C_Y  = 3'b110;

   logic       clk = 1'b0;
   logic       resetn;
   logic       move_left, move_right, drop;
   logic       cmd_ready, draw_go, draw_done;
   logic [2:0] draw_col, draw_row, draw_colour;
   logic       player, board_full, illegal_move;
   logic [5:0] piece_count;

   always #5 clk = ~clk;

   c4_draw_sequencer #(
      .COLS      (7),
      .ROWS      (6),
      .START_COL (3)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .move_left    (move_left),
      .move_right   (move_right),
      .drop         (drop),
      .cmd_ready    (cmd_ready),
      .draw_go      (draw_go),
      .draw_col     (draw_col),
      .draw_row     (draw_row),
      .draw_colour  (draw_colour),
      .draw_done    (draw_done),
      .player       (player),
      .board_full   (board_full),
      .illegal_move (illegal_move),
      .piece_count  (piece_count)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         go_rises = 0;
   int         illegal_cycles = 0;
   logic [8:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_req(input int c, input int r, input logic [2:0] colour);
      exp_q.push_back({3'(c), 3'(r), colour});
   endtask

   // Drawer model: done pulse three cycles after draw_go rises.
   initial begin
      int cnt;
      cnt = 0;
      draw_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (draw_done) begin
            draw_done = 1'b0;
            cnt = 0;
         end else if (draw_go) begin
            if (cnt == 2) begin
               draw_done = 1'b1;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: compare each new request, and check fields stay put while held.
   initial begin
      logic       go_prev;
      logic [8:0] held;
      logic [8:0] e;
      go_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (illegal_move) illegal_cycles++;
         if (draw_go && !go_prev) begin
            go_rises++;
            held = {draw_col, draw_row, draw_colour};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_request: got %0h, expected none", held);
            end else begin
               e = exp_q.pop_front();
               check("request", 32'(held), 32'(e));
            end
         end else if (draw_go) begin
            check("request_stable", 32'({draw_col, draw_row, draw_colour}), 32'(held));
         end
         go_prev = draw_go;
      end
   end

   task automatic cmd(input logic l, input logic r, input logic d);
      @(negedge clk);
      move_left  = l;
      move_right = r;
      drop       = d;
      @(posedge clk);
      #1;
      move_left  = 1'b0;
      move_right = 1'b0;
      drop       = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      check(name, 32'(cmd_ready), 32'd1);
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int rises0;
      int ill0;
      resetn     = 1'b0;
      move_left  = 1'b0;
      move_right = 1'b0;
      drop       = 1'b0;
      #12;
      check("rst_draw_go", 32'(draw_go), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_illegal", 32'(illegal_move), 32'd0);
      check("rst_player", 32'(player), 32'd0);
      check("rst_piece_count", 32'(piece_count), 32'd0);
      check("rst_board_full", 32'(board_full), 32'd0);
      check("rst_fields", 32'({draw_col, draw_row, draw_colour}), 32'd0);

      // Initial pointer draw
      expect_req(3, 6, C_R);
      @(negedge clk);
      resetn = 1'b1;
      wait_ready("init_ready");
      check("init_one_request", 32'(go_rises), 32'd1);

      // move_left from column 3
      expect_req(3, 6, C_BG);
      expect_req(2, 6, C_R);
      cmd(1'b1, 1'b0, 1'b0);
      wait_ready("left_ready");
      check("left_requests", 32'(go_rises), 32'd3);

      // Walk to column 0, then move_left is a no-op
      expect_req(2, 6, C_BG);
      expect_req(1, 6, C_R);
      cmd(1'b1, 1'b0, 1'b0);
      wait_ready("left2_ready");
      expect_req(1, 6, C_BG);
      expect_req(0, 6, C_R);
      cmd(1'b1, 1'b0, 1'b0);
      wait_ready("left3_ready");
      rises0 = go_rises;
      cmd(1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check("edge_left_no_draw", 32'(go_rises), 32'(rises0));
      check("edge_left_ready", 32'(cmd_ready), 32'd1);

      // Back to column 3
      for (int c = 0; c < 3; c++) begin
         expect_req(c, 6, C_BG);
         expect_req(c + 1, 6, C_R);
         cmd(1'b0, 1'b1, 1'b0);
         wait_ready("right_ready");
      end

      // Two drops into column 3
      expect_req(3, 0, C_R);
      expect_req(3, 6, C_Y);
      cmd(1'b0, 1'b0, 1'b1);
      wait_ready("drop1_ready");
      expect_req(3, 1, C_Y);
      expect_req(3, 6, C_R);
      cmd(1'b0, 1'b0, 1'b1);
      wait_ready("drop2_ready");
      check("drop2_count", 32'(piece_count), 32'd2);
      check("drop2_player", 32'(player), 32'd0);

      // Fill column 3
      for (int r = 2; r < 6; r++) begin
         expect_req(3, r, (r % 2 == 0) ? C_R : C_Y);
         expect_req(3, 6, (r % 2 == 0) ? C_Y : C_R);
         cmd(1'b0, 1'b0, 1'b1);
         wait_ready("fill_ready");
      end
      check("fill_count", 32'(piece_count), 32'd6);
      check("fill_player", 32'(player), 32'd0);

      // Drop into a full column is rejected, twice
      rises0 = go_rises;
      ill0   = illegal_cycles;
      cmd(1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("illegal_pulse", 32'(illegal_cycles - ill0), 32'd1);
      check("illegal_no_draw", 32'(go_rises), 32'(rises0));
      check("illegal_ready", 32'(cmd_ready), 32'd1);
      cmd(1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("illegal_again", 32'(illegal_cycles - ill0), 32'd2);
      check("illegal_count", 32'(piece_count), 32'd6);

      // Move to column 4, then drop wins over a simultaneous move_right
      expect_req(3, 6, C_BG);
      expect_req(4, 6, C_R);
      cmd(1'b0, 1'b1, 1'b0);
      wait_ready("to4_ready");
      expect_req(4, 0, C_R);
      expect_req(4, 6, C_Y);
      cmd(1'b0, 1'b1, 1'b1);
      wait_ready("prio_ready");
      check("prio_count", 32'(piece_count), 32'd7);
      check("prio_player", 32'(player), 32'd1);

      // Reset while a request is outstanding
      expect_req(4, 6, C_BG);
      cmd(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (draw_go) break;
      end
      check("midrst_go_seen", 32'(draw_go), 32'd1);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check("midrst_go_async", 32'(draw_go), 32'd0);
      check("midrst_count", 32'(piece_count), 32'd0);
      check("midrst_player", 32'(player), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd0);
      expect_req(3, 6, C_R);
      @(negedge clk);
      resetn = 1'b1;
      wait_ready("midrst_reinit");

      // Heights were cleared: a drop in column 3 lands at row 0
      expect_req(3, 0, C_R);
      expect_req(3, 6, C_Y);
      cmd(1'b0, 1'b0, 1'b1);
      wait_ready("post_rst_drop");
      check("post_rst_count", 32'(piece_count), 32'd1);
      check("post_rst_player", 32'(player), 32'd1);

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/c4_draw_sequencer.md
Name: c4_draw_sequencer

Overview:
- Initiator side of the cell-drawing handshake for the Connect Four display.
- Turns game-level commands (move pointer left, move pointer right, drop piece) into a sequence of single-cell draw requests (go/done) for the pixel-drawing controller.
- Tracks pointer column, per-column fill heights, current player and piece count.
- Sits between the keyboard/button front end and the 4x4-pixel cell drawer that feeds the VGA adapter.

Parameters:
- COLS, 7, number of board columns (column index 0..COLS-1, 3-bit).
- ROWS, 6, number of board rows (row 0 = bottom; row index ROWS = pointer row above the board).
- START_COL, 3, pointer column after reset.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- move_left  input  1  one-cycle command pulse
- move_right  input  1  one-cycle command pulse
- drop  input  1  one-cycle command pulse
- cmd_ready  output  1  high only in IDLE; commands are sampled only when high
- draw_go  output  1  draw request to the cell drawer
- draw_col  output  3  cell column of the request
- draw_row  output  3  cell row of the request (ROWS = pointer row)
- draw_colour  output  3  colour of the request
- draw_done  input  1  drawer completion pulse
- player  output  1  current player (0 = red, 1 = yellow)
- board_full  output  1  high when piece_count == COLS*ROWS
- illegal_move  output  1  one-cycle pulse on rejected drop
- piece_count  output  6  pieces placed so far

Behaviour:
- Reset is asynchronous and active-low on resetn; clock is clk.
- Reset values:
  - draw_go = 0, cmd_ready = 0, illegal_move = 0.
  - player = 0, piece_count = 0, board_full = 0, all column heights = 0.
  - Pointer column = START_COL; draw_col/draw_row/draw_colour = 0.
  - State = INIT_PTR.
- Colours:
  - Background = 000; red = 100; yellow = 110.
  - The pointer is drawn in the current player's colour.
- Handshake (every draw state):
  - On state entry, draw_col/row/colour are registered, and draw_go goes high the next cycle.
  - draw_go and the request fields are held stable until draw_done is sampled high while draw_go = 1.
  - In the following cycle draw_go = 0; the FSM then moves on.
  - Each request therefore has draw_go low for at least one cycle before the next rises.
  - draw_done while draw_go = 0 is ignored.
- States:
  - INIT_PTR: draw the pointer at (START_COL, ROWS), then go to IDLE.
  - IDLE: cmd_ready = 1. Commands are decoded in the same cycle with priority drop > move_left > move_right; other simultaneous pulses are discarded.
    - drop, column height < ROWS: go to DRAW_PIECE.
    - drop, column full, or board_full: illegal_move pulses for 1 cycle; stay in IDLE.
    - move_left at column 0: no-op, no draw.
    - move_right at column COLS-1: no-op, no draw.
    - Otherwise move_left/move_right go to ERASE_PTR with the target column latched.
  - ERASE_PTR: draw background at (old col, ROWS); on completion update the pointer column; go to DRAW_PTR.
  - DRAW_PIECE: draw the player colour at (col, height[col]). On completion:
    - height[col] += 1, piece_count += 1, player toggles.
    - Go to DRAW_PTR (redraws the pointer in the new player's colour at the same column).
  - DRAW_PTR: draw the pointer at (col, ROWS), then go to IDLE.
- Commands arriving outside IDLE are ignored (not queued).
- Height counters saturate at ROWS; piece_count saturates at COLS*ROWS.
- board_full is combinational from piece_count.
- Reset mid-request: draw_go drops immediately, all state is cleared, and the sequence restarts at INIT_PTR after resetn rises.

Decomposition:
- Shared package c4_pkg:
  - Colour constants: BG, RED, YELLOW.
  - Board dimension defaults.
  - State enum.
  - Coordinate widths (col/row 3 bits).
- One sub-module, c4_draw_req: a handshake holder.
  - Inputs: start, col/row/colour; draw_done.
  - Outputs: draw_go/fields, req_complete pulse.
  - The main FSM uses it for every draw state.

Test Plan:
- Reset release, drawer responds with done 3 cycles after go -> first request is (3,6,100); cmd_ready rises only after that done, and draw_go has a low cycle in between.
- IDLE, move_left -> requests (3,6,000), then (2,6,100); pointer col = 2; cmd_ready back high.
- Pointer at col 0, move_left -> no draw_go, cmd_ready stays 1, state unchanged.
- drop at col 3 twice -> requests (3,0,100), (3,6,110), (3,1,110), (3,6,100); piece_count = 2; player = 0.
- Six drops into col 3, then a seventh -> seventh gives an illegal_move 1-cycle pulse and no draw_go; height stays 6.
- drop and move_right in the same IDLE cycle -> only the drop sequence runs. Separately: resetn low while draw_go = 1 -> draw_go = 0 asynchronously, piece_count = 0, INIT_PTR request reissued.
